// File: rtl/mux_2_1_arb.sv
// Two-channel round-robin packet arbiter driving a 2:1 mux select, with a
// one-entry registered output stage (one beat per clock, one cycle latency).
module mux_2_1_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  input  logic             i0_last,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  input  logic             i1_last,
  output logic             i1_ready,
  output logic             s0,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;

  logic             load;
  logic             sel;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;

  // The output register may be refilled in the same cycle it drains.
  assign load = !y_valid_q || y_ready;

  always_comb begin
    sel = prio_q;
    unique case (state_q)
      LOCK0: sel = 1'b0;
      LOCK1: sel = 1'b1;
      default: begin
        if (i0_valid && !i1_valid)
          sel = 1'b0;
        else if (i1_valid && !i0_valid)
          sel = 1'b1;
        else
          sel = prio_q;
      end
    endcase
  end

  assign sel_valid = sel ? i1_valid : i0_valid;
  assign sel_last  = sel ? i1_last  : i0_last;
  assign sel_data  = sel ? i1_data  : i0_data;
  assign xfer      = load && sel_valid && !rst;

  assign s0       = sel;
  assign i0_ready = load && !rst && !sel;
  assign i1_ready = load && !rst && sel;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;

    if (xfer) begin
      y_data_d  = sel_data;
      y_last_d  = sel_last;
      y_valid_d = 1'b1;

      unique case (state_q)
        LOCK0, LOCK1: begin
          if (sel_last) begin
            state_d = ARB;
            prio_d  = !sel;
          end
        end
        default: begin
          // A single-beat packet releases the grant without ever locking.
          if (sel_last) begin
            state_d = ARB;
            prio_d  = !sel;
          end else begin
            state_d = sel ? LOCK1 : LOCK0;
          end
        end
      endcase
    end else if (y_ready && y_valid_q) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      prio_q    <= 1'b0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;

endmodule

// File: doc/mux_2_1_arb.md
# mux_2_1_arb

Two-channel packet arbiter that sits directly upstream of the 2:1 mux select line. It round-robin-arbitrates two valid/ready sources, holds the grant for a whole packet, and drives the select `s0`. It also provides a one-entry registered output stage that carries the selected beat downstream. Throughput is one beat per clock with one cycle of latency.

## Interface
- `WIDTH`, 8, data width of each channel and of the output
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `i0_data`  in  WIDTH  channel-0 beat
- `i0_valid`  in  1  channel-0 beat present
- `i0_last`  in  1  channel-0 beat ends its packet
- `i0_ready`  out  1  channel-0 beat accepted this cycle when high with `i0_valid`
- `i1_data`, `i1_valid`, `i1_last`, `i1_ready`: same as channel 0, for channel 1
- `s0`  out  1  combinational select: 0 = channel 0, 1 = channel 1
- `y_data`  out  WIDTH  registered output beat
- `y_valid`  out  1  output beat present
- `y_last`  out  1  output beat ends its packet
- `y_ready`  in  1  downstream accepts the output beat

## Operation
- **Registers**
  - FSM state: `ARB`, `LOCK0`, `LOCK1`.
  - `prio` (1 bit): the channel favoured on a tie.
  - Output register: `y_data`, `y_valid`, `y_last`.
- **Load enable:** `load = !y_valid || y_ready`, so the output register can be refilled in the same cycle it drains.
- **Select `s0`**
  - In `ARB`:
    - If only one channel is valid, `s0` selects that channel.
    - If both are valid, `s0` = `prio`.
    - If neither is valid, `s0` = `prio`.
  - In `LOCK0`, `s0` = 0. In `LOCK1`, `s0` = 1. Requests from the other channel are ignored.
- **Ready outputs**
  - `i0_ready = load && s0==0`
  - `i1_ready = load && s0==1`
  - The unselected channel always sees ready = 0.
- **Transfer:** `xfer = load && selected valid`. On `xfer`, the output register captures the selected channel's data and last, and sets `y_valid` = 1.
- **Drain without refill:** on `y_ready && y_valid && !xfer`, `y_valid` goes to 0. `y_data` and `y_last` hold their values.
- **FSM transitions** (evaluated only on `xfer`):
  - `ARB`, selected last = 1: stay in `ARB`; `prio` becomes the non-selected channel.
  - `ARB`, selected last = 0: go to `LOCK<sel>`; `prio` is unchanged.
  - `LOCK<k>`, last = 0: stay in `LOCK<k>`.
  - `LOCK<k>`, last = 1: go to `ARB`; `prio` becomes channel 1−k.
- **No transfer:** state and `prio` hold. This includes a locked channel with `valid` low, which keeps the lock.
- **Single-beat packets:** a packet with last = 1 on its first beat never enters a LOCK state.

## Timing
- **Reset** (synchronous, `rst` high at a clock edge):
  - State = `ARB`, `prio` = 0.
  - `y_valid` = 0, `y_data` = 0, `y_last` = 0.
  - While `rst` is high, both ready outputs are forced to 0.
  - `s0` is combinational and reflects the reset state once reset has been applied.
- **Reset mid-packet:** the lock is dropped and any pending output beat is discarded. There is no recovery of the partial packet.
- **Latency:** a beat accepted at edge N appears on `y_*` after edge N, i.e. one cycle.
- **Throughput:** with `y_ready` held high, one beat per cycle is sustained. Channel switch-over at a packet boundary adds no bubble.
- **Backpressure:** while `y_valid && !y_ready`, both ready outputs are 0 and `y_data`/`y_last` are stable.
- **Same-cycle handshakes:** downstream accept and upstream accept in the same cycle are legal, and the register is refilled.
- **Input stability:** inputs may change only after an accept. The block does not require a channel's valid to stay high.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both channels valid → `y_valid`=0, `y_data`=0, `i0_ready`=`i1_ready`=0. On the first cycle after `rst` drops, `s0`=0.
- **Tie-break / round robin:** both channels send continuous single-beat packets (last = 1, i0 = 0xA0.., i1 = 0xB0..) with `y_ready`=1 → output alternates A0, B0, A1, B1…, one beat per cycle.
- **Packet lock:** i0 sends a 3-beat packet 0x11/0x12/0x13 (last on 0x13) while i1 is valid with 0x22 → `y` = 11, 12, 13, 22. `i1_ready`=0 for the first three transfers.
- **Backpressure:** hold `y_ready`=0 for 4 cycles while 0x55 is on the output → `y_data`=0x55 is stable and both readies are 0. Release → one beat drains per cycle with no loss or duplication.
- **Lock with gap:** in `LOCK1`, drop `i1_valid` for 2 cycles while i0 is valid → no i0 beat is accepted and `s0` stays 1. The packet resumes when `i1_valid` returns.
- **Reset mid-packet:** assert `rst` after beat 1 of an i1 multi-beat packet, with `prio` = 1 before reset → after reset the state is `ARB`, `prio`=0, `y_valid`=0. If both channels are then valid, i0 is granted first.
